io_responder: RTL and testbench

IO_RESPONDER -- requirements
Module: io_responder

---
 rtl/io_responder_pkg.sv | 14 +
 rtl/io_responder_if.sv | 31 +++
 rtl/io_responder_fifo.sv | 49 ++++
 rtl/io_responder.sv | 134 +++++++++++++
 tb/tb_io_responder.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/io_responder_pkg.sv
// Shared definitions for the io_responder block: handshake FSM encoding and
// default data/FIFO geometry.
package io_responder_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACK      = 2'd1,
        ST_WAIT_REL = 2'd2
    } io_state_e;

endpackage

// File: rtl/io_responder_if.sv
// CPU handshake and host FIFO signals of io_responder, bundled for port use.
interface io_responder_if #(
    parameter int WIDTH = io_responder_pkg::DEF_WIDTH
);

    logic             inp_req;
    logic [WIDTH-1:0] inp_data;
    logic             inp_ack;
    logic             out_req;
    logic [WIDTH-1:0] out_data;
    logic             out_ack;

    logic             host_wr_en;
    logic [WIDTH-1:0] host_wr_data;
    logic             host_full;
    logic             host_rd_en;
    logic [WIDTH-1:0] host_rd_data;
    logic             host_empty;
    logic             overflow;

    modport slave (
        input  inp_req, out_req, out_data, host_wr_en, host_wr_data, host_rd_en,
        output inp_data, inp_ack, out_ack, host_full, host_rd_data, host_empty, overflow
    );

    modport master (
        output inp_req, out_req, out_data, host_wr_en, host_wr_data, host_rd_en,
        input  inp_data, inp_ack, out_ack, host_full, host_rd_data, host_empty, overflow
    );

endinterface

// File: rtl/io_responder_fifo.sv
// Synchronous first-word-fall-through FIFO with wrap-bit pointers. A push into a
// full FIFO is accepted only when a pop frees the slot on the same edge.
module io_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_rd;
    logic             w_do_wr;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

    assign w_do_rd = i_rd_en && !o_empty;
    assign w_do_wr = i_wr_en && (!o_full || w_do_rd);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // Storage carries no reset; emptiness is tracked purely by the pointers.
    always_ff @(posedge clk) begin
        if (w_do_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end

endmodule

// File: rtl/io_responder.sv
// CPU-facing request/ack responder backed by a host-fed input FIFO and a
// host-drained output FIFO.
//   state       | meaning
//   ST_IDLE     | waiting for req (and FIFO room/data)
//   ST_ACK      | ack pulse high for this cycle
//   ST_WAIT_REL | waiting for req to drop before re-arming
module io_responder
    import io_responder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic           clk,
    input  logic           rst_b,
    io_responder_if.slave  bus
);

    io_state_e        r_inp_state;
    io_state_e        r_out_state;
    logic [WIDTH-1:0] r_inp_data;
    logic             r_inp_ack;
    logic             r_out_ack;
    logic             r_overflow;

    logic [WIDTH-1:0] w_in_head;
    logic             w_in_full;
    logic             w_in_empty;
    logic             w_in_pop;
    logic             w_out_full;
    logic             w_out_empty;
    logic             w_out_push;

    assign w_in_pop   = (r_inp_state == ST_IDLE) && bus.inp_req && !w_in_empty;
    assign w_out_push = (r_out_state == ST_IDLE) && bus.out_req && !w_out_full;

    io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_in_fifo (
        .clk       (clk),
        .rst_b     (rst_b),
        .i_wr_en   (bus.host_wr_en),
        .i_wr_data (bus.host_wr_data),
        .i_rd_en   (w_in_pop),
        .o_rd_data (w_in_head),
        .o_full    (w_in_full),
        .o_empty   (w_in_empty)
    );

    io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_out_fifo (
        .clk       (clk),
        .rst_b     (rst_b),
        .i_wr_en   (w_out_push),
        .i_wr_data (bus.out_data),
        .i_rd_en   (bus.host_rd_en),
        .o_rd_data (bus.host_rd_data),
        .o_full    (w_out_full),
        .o_empty   (w_out_empty)
    );

    assign bus.inp_data   = r_inp_data;
    assign bus.inp_ack    = r_inp_ack;
    assign bus.out_ack    = r_out_ack;
    assign bus.host_full  = w_in_full;
    assign bus.host_empty = w_out_empty;
    assign bus.overflow   = r_overflow;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_inp_state <= ST_IDLE;
            r_inp_data  <= '0;
            r_inp_ack   <= 1'b0;
        end else begin
            case (r_inp_state)
                ST_IDLE: begin
                    r_inp_ack <= 1'b0;
                    if (w_in_pop) begin
                        r_inp_data  <= w_in_head;
                        r_inp_ack   <= 1'b1;
                        r_inp_state <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    r_inp_ack   <= 1'b0;
                    r_inp_state <= ST_WAIT_REL;
                end
                ST_WAIT_REL: begin
                    r_inp_ack <= 1'b0;
                    if (!bus.inp_req) r_inp_state <= ST_IDLE;
                end
                default: begin
                    r_inp_ack   <= 1'b0;
                    r_inp_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_out_state <= ST_IDLE;
            r_out_ack   <= 1'b0;
        end else begin
            case (r_out_state)
                ST_IDLE: begin
                    r_out_ack <= 1'b0;
                    if (w_out_push) begin
                        r_out_ack   <= 1'b1;
                        r_out_state <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    r_out_ack   <= 1'b0;
                    r_out_state <= ST_WAIT_REL;
                end
                ST_WAIT_REL: begin
                    r_out_ack <= 1'b0;
                    if (!bus.out_req) r_out_state <= ST_IDLE;
                end
                default: begin
                    r_out_ack   <= 1'b0;
                    r_out_state <= ST_IDLE;
                end
            endcase
        end
    end

    // A push that coincides with a CPU pop on a full FIFO is accepted, so it is not an overflow.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_overflow <= 1'b0;
        end else if (bus.host_wr_en && w_in_full && !w_in_pop) begin
            r_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_io_responder.sv
// Directed bench for io_responder: handshakes, FIFO boundaries, wrap and reset.
module tb_io_responder;

    logic clk;
    logic rst_b;
    int   n_checks;
    int   n_fail;
    logic [15:0] q_model[$];
    logic [15:0] w_exp;

    io_responder_if #(.WIDTH(16)) bus ();

    io_responder #(.WIDTH(16), .DEPTH(8)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic host_push(input logic [15:0] w);
        bus.host_wr_en   = 1'b1;
        bus.host_wr_data = w;
        tick();
        bus.host_wr_en   = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_b = 1'b0;
        bus.inp_req = 1'b0;
        bus.out_req = 1'b0;
        bus.out_data = '0;
        bus.host_wr_en = 1'b0;
        bus.host_wr_data = '0;
        bus.host_rd_en = 1'b0;
        #12;
        chk("rst_inp_ack", bus.inp_ack, 0);
        chk("rst_out_ack", bus.out_ack, 0);
        chk("rst_inp_data", bus.inp_data, 0);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_full", bus.host_full, 0);
        chk("rst_empty", bus.host_empty, 1);
        rst_b = 1'b1;
        tick();
        tick();

        // Basic input handshake, no re-ack while req held.
        host_push(16'h1234);
        bus.inp_req = 1'b1;
        tick();
        chk("in_ack1", bus.inp_ack, 1);
        chk("in_data1", bus.inp_data, 16'h1234);
        tick();
        chk("in_ack1_end", bus.inp_ack, 0);
        host_push(16'h5555);
        chk("in_no_reack_a", bus.inp_ack, 0);
        tick();
        chk("in_no_reack_b", bus.inp_ack, 0);
        chk("in_data_hold", bus.inp_data, 16'h1234);
        bus.inp_req = 1'b0;
        tick();
        chk("in_release", bus.inp_ack, 0);
        bus.inp_req = 1'b1;
        tick();
        chk("in_ack2", bus.inp_ack, 1);
        chk("in_data2", bus.inp_data, 16'h5555);
        bus.inp_req = 1'b0;
        tick();
        tick();

        // Request pending on an empty FIFO.
        bus.inp_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("in_wait_empty", bus.inp_ack, 0);
        end
        host_push(16'hBEEF);
        chk("in_push_edge", bus.inp_ack, 0);
        tick();
        chk("in_ack3", bus.inp_ack, 1);
        chk("in_data3", bus.inp_data, 16'hBEEF);
        bus.inp_req = 1'b0;
        tick();
        tick();

        // Output channel: fill to 8, ninth blocks until host pops.
        for (int i = 1; i <= 8; i++) begin
            bus.out_data = 16'(i);
            bus.out_req  = 1'b1;
            tick();
            chk("out_ack_fill", bus.out_ack, 1);
            bus.out_req = 1'b0;
            tick();
            tick();
        end
        chk("out_not_empty", bus.host_empty, 0);
        bus.out_data = 16'h0009;
        bus.out_req  = 1'b1;
        tick();
        chk("out_full_block_a", bus.out_ack, 0);
        tick();
        chk("out_full_block_b", bus.out_ack, 0);
        chk("host_rd_first", bus.host_rd_data, 16'h0001);
        bus.host_rd_en = 1'b1;
        tick();
        bus.host_rd_en = 1'b0;
        chk("out_pop_edge", bus.out_ack, 0);
        tick();
        chk("out_ack9", bus.out_ack, 1);
        bus.out_req = 1'b0;
        tick();
        tick();
        for (int i = 2; i <= 9; i++) begin
            chk("host_rd_order", bus.host_rd_data, 32'(i));
            bus.host_rd_en = 1'b1;
            tick();
            bus.host_rd_en = 1'b0;
        end
        chk("out_drained", bus.host_empty, 1);
        bus.host_rd_en = 1'b1;
        tick();
        bus.host_rd_en = 1'b0;
        chk("out_pop_empty", bus.host_empty, 1);

        // Input FIFO full and overflow.
        for (int i = 0; i < 8; i++) begin
            chk("in_not_full", bus.host_full, 0);
            host_push(16'h0100 + 16'(i));
            q_model.push_back(16'h0100 + 16'(i));
        end
        chk("in_full", bus.host_full, 1);
        chk("no_overflow_yet", bus.overflow, 0);
        host_push(16'h0999);
        chk("overflow_set", bus.overflow, 1);
        chk("in_full_after_drop", bus.host_full, 1);
        tick();
        tick();
        chk("overflow_sticky", bus.overflow, 1);

        // Full-FIFO simultaneous push + CPU pop across pointer wrap.
        for (int k = 0; k < 20; k++) begin
            bus.inp_req      = 1'b1;
            bus.host_wr_en   = 1'b1;
            bus.host_wr_data = 16'h0200 + 16'(k);
            tick();
            w_exp = q_model.pop_front();
            q_model.push_back(16'h0200 + 16'(k));
            chk("wrap_ack", bus.inp_ack, 1);
            chk("wrap_data", bus.inp_data, w_exp);
            chk("wrap_full", bus.host_full, 1);
            bus.inp_req    = 1'b0;
            bus.host_wr_en = 1'b0;
            tick();
            tick();
        end
        chk("wrap_overflow", bus.overflow, 1);

        // Reset during the ACK cycle.
        bus.inp_req = 1'b1;
        tick();
        chk("pre_rst_ack", bus.inp_ack, 1);
        rst_b = 1'b0;
        #1;
        chk("rst_mid_ack", bus.inp_ack, 0);
        chk("rst_mid_empty", bus.host_empty, 1);
        chk("rst_mid_overflow", bus.overflow, 0);
        chk("rst_mid_full", bus.host_full, 0);
        chk("rst_mid_data", bus.inp_data, 0);
        #2;
        rst_b = 1'b1;
        tick();
        chk("post_rst_empty_wait", bus.inp_ack, 0);
        host_push(16'h4321);
        chk("post_rst_push_edge", bus.inp_ack, 0);
        tick();
        chk("post_rst_ack", bus.inp_ack, 1);
        chk("post_rst_data", bus.inp_data, 16'h4321);
        tick();
        chk("post_rst_single_a", bus.inp_ack, 0);
        tick();
        chk("post_rst_single_b", bus.inp_ack, 0);
        bus.inp_req = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
